// File: rtl/inst_enc_pkg.sv
// rtl/inst_enc_pkg.sv - opcode constants and format encoding shared by the instruction encoder
package inst_enc_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_BRANCH = 7'd99;

  typedef enum logic [1:0] {
    FMT_I   = 2'd0,
    FMT_S   = 2'd1,
    FMT_SB  = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

endpackage

// File: rtl/imm_fit_check.sv
// rtl/imm_fit_check.sv - combinational check that a 32-bit immediate is representable in a format
module imm_fit_check
  import inst_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [31:0] imm,
  output logic        fit
);

  logic hi11_same;
  logic hi12_same;
  logic unused_mid_bits;

  assign hi11_same       = (&imm[31:11]) | ~(|imm[31:11]);
  assign hi12_same       = (&imm[31:12]) | ~(|imm[31:12]);
  assign unused_mid_bits = ^imm[10:1];

  // Branch offsets are in halfwords, so bit 0 must be clear as well.
  always_comb begin
    fit = 1'b0;
    case (fmt)
      FMT_I, FMT_S: fit = hi11_same;
      FMT_SB:       fit = hi12_same & ~imm[0];
      default:      fit = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - 2-stage RV32 I/S/SB instruction word encoder with range flagging
// Optional INST_ENC_STATS_EN adds saturating enc_count/err_count outputs.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic              out_err
`ifdef INST_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0]  enc_count,
  output logic [CNT_W-1:0]  err_count
`endif
);

  logic        s1_valid_q, s1_valid_d;
  fmt_e        s1_fmt_q, s1_fmt_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic [4:0]  s1_rs1_q, s1_rs1_d;
  logic [4:0]  s1_rs2_q, s1_rs2_d;
  logic [2:0]  s1_f3_q, s1_f3_d;
  logic [12:0] s1_imm_q, s1_imm_d;
  logic        s1_err_q, s1_err_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_err_q, out_err_d;

  logic        s2_can_load;
  logic        in_fire;
  logic        out_fire;
  logic        imm_fit;
  logic [31:0] packed_inst;

  imm_fit_check u_fit (
    .fmt (fmt_e'(in_fmt)),
    .imm (in_imm),
    .fit (imm_fit)
  );

  assign s2_can_load = ~out_valid_q | out_ready;
  assign in_ready    = ~s1_valid_q | s2_can_load;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid_q & out_ready;

  // Out-of-range immediates are still packed from their low bits; only the flag differs.
  always_comb begin
    packed_inst = 32'h0;
    case (s1_fmt_q)
      FMT_I:   packed_inst = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, OPC_LOAD};
      FMT_S:   packed_inst = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                              s1_imm_q[4:0], OPC_STORE};
      FMT_SB:  packed_inst = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                              s1_imm_q[4:1], s1_imm_q[11], OPC_BRANCH};
      default: packed_inst = 32'h0;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fmt_d    = s1_fmt_q;
    s1_rd_d     = s1_rd_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_f3_d     = s1_f3_q;
    s1_imm_d    = s1_imm_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;

    if (s2_can_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_inst_d = packed_inst;
        out_err_d  = s1_err_q;
      end
      s1_valid_d = 1'b0;
    end

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_fmt_d   = fmt_e'(in_fmt);
      s1_rd_d    = in_rd;
      s1_rs1_d   = in_rs1;
      s1_rs2_d   = in_rs2;
      s1_f3_d    = in_funct3;
      s1_imm_d   = in_imm[12:0];
      s1_err_d   = ~imm_fit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= FMT_I;
      s1_rd_q     <= 5'd0;
      s1_rs1_q    <= 5'd0;
      s1_rs2_q    <= 5'd0;
      s1_f3_q     <= 3'd0;
      s1_imm_q    <= 13'd0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_f3_q     <= s1_f3_d;
      s1_imm_q    <= s1_imm_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;

`ifdef INST_ENC_STATS_EN
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (out_fire && !(&enc_count_q)) enc_count_d = enc_count_q + 1'b1;
    if (out_fire && out_err_q && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign enc_count = enc_count_q;
  assign err_count = err_count_q;
`else
  logic             unused_out_fire;
  logic [CNT_W-1:0] unused_cnt;
  assign unused_out_fire = out_fire;
  assign unused_cnt      = '0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder with random stimulus and a reference model
module tb_inst_encoder;

  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
`ifdef INST_ENC_STATS_EN
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;
`endif

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err)
`ifdef INST_ENC_STATS_EN
    ,
    .enc_count (enc_count),
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pops = 0;
  int   n_err_pops = 0;
  logic held_v = 1'b0;
  logic [31:0] held_inst;
  logic        held_err;
  logic        rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: range from signed bounds, fields placed by shifting extracted immediate bits.
  function automatic exp_t model(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    int          si;
    logic        ok;
    logic [31:0] base;
    logic [31:0] r;
    exp_t        e;
    si   = $signed(imm);
    base = ({27'd0, rs1} << 15) | ({29'd0, f3} << 12);
    case (f)
      2'd0: begin
        ok = (si >= -2048) && (si <= 2047);
        r  = ((imm & 32'hFFF) << 20) | base | ({27'd0, rd} << 7) | 32'd3;
      end
      2'd1: begin
        ok = (si >= -2048) && (si <= 2047);
        r  = (((imm >> 5) & 32'h7F) << 25) | ({27'd0, rs2} << 20) | base
           | ((imm & 32'h1F) << 7) | 32'd35;
      end
      2'd2: begin
        ok = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
        r  = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25)
           | ({27'd0, rs2} << 20) | base | (((imm >> 1) & 32'hF) << 8)
           | (((imm >> 11) & 32'd1) << 7) | 32'd99;
      end
      default: begin
        ok = 1'b0;
        r  = 32'h0;
      end
    endcase
    e.inst = r;
    e.err  = ~ok;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      held_v     = 1'b0;
      n_pops     = 0;
      n_err_pops = 0;
    end else if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected no word at %0t", out_inst, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_inst", out_inst, mon_e.inst);
        check("out_err", {31'd0, out_err}, {31'd0, mon_e.err});
      end
      n_pops++;
      if (out_err) n_err_pops++;
      held_v = 1'b0;
    end else if (out_valid) begin
      if (held_v) begin
        check("hold_inst", out_inst, held_inst);
        check("hold_err", {31'd0, out_err}, {31'd0, held_err});
      end
      held_v    = 1'b1;
      held_inst = out_inst;
      held_err  = out_err;
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    logic done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_fmt    = f;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(f, rd, rs1, rs2, f3, imm));
        done = 1'b1;
      end
      step();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck low, expected acceptance");
    end
  endtask

  task automatic directed(input string nm, input logic [1:0] f, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [31:0] imm, input logic chk_inst,
                          input logic [31:0] exp_inst, input logic exp_err);
    out_ready = 1'b1;
    send(f, rd, rs1, rs2, f3, imm);
    in_valid = 1'b0;
    check({nm, "_lat1"}, {31'd0, out_valid}, 32'd0);
    step();
    check({nm, "_lat2"}, {31'd0, out_valid}, 32'd1);
    check({nm, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    if (chk_inst) check({nm, "_inst"}, out_inst, exp_inst);
    step();
  endtask

  initial begin
    int v;
    logic [31:0] imm;
    logic [1:0]  f;
    int bnd[9] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4097, 4096};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_fmt    = 2'd0;
    in_rd     = 5'd0;
    in_rs1    = 5'd0;
    in_rs2    = 5'd0;
    in_funct3 = 3'd0;
    in_imm    = 32'd0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef INST_ENC_STATS_EN
    check("rst_enc_count", {16'd0, enc_count}, 32'd0);
`endif

    directed("i_enc", 2'd0, 5'd5, 5'd2, 5'd0, 3'd2, 32'hFFFF_FFFC, 1'b1, 32'hFFC12283, 1'b0);
    directed("s_enc", 2'd1, 5'd0, 5'd2, 5'd5, 3'd2, 32'd8, 1'b1, 32'h00512423, 1'b0);
    directed("sb_enc", 2'd2, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8, 1'b1, 32'hFE208CE3, 1'b0);
    directed("i_range", 2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 32'd2048, 1'b0, 32'd0, 1'b1);
    directed("sb_odd", 2'd2, 5'd0, 5'd3, 5'd4, 3'd1, 32'd3, 1'b0, 32'd0, 1'b1);
    directed("rsv", 2'd3, 5'd7, 5'd7, 5'd7, 3'd7, 32'd4, 1'b1, 32'd0, 1'b1);

    // Backpressure: two requests fill the pipe, the third must stall.
    out_ready = 1'b0;
    send(2'd0, 5'd1, 5'd2, 5'd3, 3'd1, 32'd100);
    send(2'd1, 5'd4, 5'd5, 5'd6, 3'd2, -32'sd100);
    in_valid = 1'b1;
    in_fmt   = 2'd2;
    in_imm   = 32'd64;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    send(2'd2, 5'd0, 5'd9, 5'd10, 3'd4, 32'd64);
    in_valid = 1'b0;
    check("bp_drain0", {31'd0, out_valid}, 32'd1);
    step();
    check("bp_drain1", {31'd0, out_valid}, 32'd1);
    step();
    check("bp_drain2", {31'd0, out_valid}, 32'd0);

    // Reset with two requests in flight.
    out_ready = 1'b0;
    send(2'd0, 5'd11, 5'd12, 5'd0, 3'd3, 32'd5);
    send(2'd1, 5'd0, 5'd13, 5'd14, 3'd3, 32'd6);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_inst", out_inst, 32'd0);
    sb_q.delete();
    step();
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
`ifdef INST_ENC_STATS_EN
    check("rst2_enc_count", {16'd0, enc_count}, 32'd0);
    check("rst2_err_count", {16'd0, err_count}, 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
    end
    directed("post_rst", 2'd2, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8, 1'b1, 32'hFE208CE3, 1'b0);

    // Random traffic with random backpressure.
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 4095)) - 2048;
        1: v = int'($urandom_range(0, 16383)) - 8192;
        2: v = int'($urandom());
        default: v = bnd[$urandom_range(0, 8)];
      endcase
      imm = v;
      f   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      send(f, 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()), imm);
    end
    in_valid  = 1'b0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step();
    step();
    check("drain_empty", sb_q.size(), 32'd0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);
`ifdef INST_ENC_STATS_EN
    check("enc_count", {16'd0, enc_count}, n_pops);
    check("err_count", {16'd0, err_count}, n_err_pops);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
